// File: rtl/pgm_video_pkg.sv
// Shared types and constants for the pgm_video sprite path.
package pgm_video_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StFill,
        StSwap
    } dma_state_t;

    localparam int unsigned SPR_WORDS_PER_ENTRY = 4;
    localparam int unsigned SPR_SIZE_WORD_IDX   = 2;

endpackage

// File: rtl/pgm_sprite_bank_ram.sv
// One 1024x16 sprite attribute bank: a write port and a registered read port.
module pgm_sprite_bank_ram (
    input  logic        clk,
    input  logic        we,
    input  logic [9:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [9:0]  raddr,
    output logic [15:0] rdata
);

    logic [15:0] mem [1024];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/pgm_sprite_dma.sv
// Sprite-list DMA from work RAM into a double-buffered attribute table, flipped at each vsync.
// Define PGM_SPRITE_DMA_EOL_EN to zero-fill the table after the first entry with a zero size word.
module pgm_sprite_dma
    import pgm_video_pkg::*;
#(
    parameter int unsigned WORDS     = 1024,
    parameter logic [14:0] WRAM_BASE = 15'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vs,
    input  logic        dma_en,
    output logic        wram_rd,
    output logic [14:0] wram_addr,
    input  logic        wram_ack,
    input  logic [15:0] wram_dout,
    input  logic [9:0]  sprite_addr,
    output logic [15:0] sprite_dout,
    output logic        busy,
    output logic        overrun
);

    dma_state_t  state_q;
    logic [10:0] cnt_q;
    logic        front_q, vs_q, rd_sel_q, rd_valid_q;
    logic        trig, take, size_zero, bank_we;
    logic [15:0] bank_wdata, rdata0, rdata1;

    assign trig = vs_q & ~vs;
    assign take = (state_q == StRead) & wram_rd & wram_ack;
    assign busy = (state_q != StIdle);

`ifdef PGM_SPRITE_DMA_EOL_EN
    assign size_zero = (cnt_q[1:0] == 2'(SPR_SIZE_WORD_IDX)) & (wram_dout == 16'h0000);
`else
    assign size_zero = 1'b0;
`endif

    assign bank_we    = take | (state_q == StFill);
    assign bank_wdata = (state_q == StFill) ? 16'h0000 : wram_dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            front_q   <= 1'b0;
            vs_q      <= 1'b1;
            wram_rd   <= 1'b0;
            wram_addr <= WRAM_BASE;
            overrun   <= 1'b0;
        end else begin
            vs_q <= vs;
            if (trig && state_q != StIdle) begin
                overrun <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (trig && dma_en) begin
                        state_q   <= StRead;
                        cnt_q     <= '0;
                        wram_rd   <= 1'b1;
                        wram_addr <= WRAM_BASE;
                    end
                end
                StRead: begin
                    if (take) begin
                        wram_rd <= 1'b0;
                        cnt_q   <= cnt_q + 11'd1;
                        if (size_zero) begin
                            state_q <= StFill;
                        end
                    end else if (!wram_rd) begin
                        // The idle cycle after the last ack hands over to the flip.
                        if (cnt_q == 11'(WORDS)) begin
                            state_q <= StSwap;
                        end else begin
                            wram_rd   <= 1'b1;
                            wram_addr <= WRAM_BASE + 15'(cnt_q);
                        end
                    end
                end
`ifdef PGM_SPRITE_DMA_EOL_EN
                StFill: begin
                    cnt_q <= cnt_q + 11'd1;
                    if (cnt_q[9:0] == 10'h3FF) begin
                        state_q <= StSwap;
                    end
                end
`endif
                StSwap: begin
                    front_q <= ~front_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Bank select is captured with the read so a flip applies from the next read on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sel_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_sel_q   <= front_q;
            rd_valid_q <= 1'b1;
        end
    end

    assign sprite_dout = !rd_valid_q ? 16'h0000 : (rd_sel_q ? rdata1 : rdata0);

    pgm_sprite_bank_ram u_bank0 (
        .clk   (clk),
        .we    (bank_we & front_q),
        .waddr (cnt_q[9:0]),
        .wdata (bank_wdata),
        .raddr (sprite_addr),
        .rdata (rdata0)
    );

    pgm_sprite_bank_ram u_bank1 (
        .clk   (clk),
        .we    (bank_we & ~front_q),
        .waddr (cnt_q[9:0]),
        .wdata (bank_wdata),
        .raddr (sprite_addr),
        .rdata (rdata1)
    );

endmodule

// File: tb/tb_pgm_sprite_dma.sv
// Self-checking bench for pgm_sprite_dma: work-RAM responder, bank model and readback scoreboard.
module tb_pgm_sprite_dma;

    localparam int unsigned WORDS = 1024;
    localparam logic [14:0] BASE  = 15'h7F00;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vs = 1'b1;
    logic        dma_en = 1'b1;
    logic        wram_rd;
    logic [14:0] wram_addr;
    logic        wram_ack = 1'b0;
    logic [15:0] wram_dout = 16'h0000;
    logic [9:0]  sprite_addr = 10'h000;
    logic [15:0] sprite_dout;
    logic        busy;
    logic        overrun;

    pgm_sprite_dma #(
        .WORDS     (WORDS),
        .WRAM_BASE (BASE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .vs          (vs),
        .dma_en      (dma_en),
        .wram_rd     (wram_rd),
        .wram_addr   (wram_addr),
        .wram_ack    (wram_ack),
        .wram_dout   (wram_dout),
        .sprite_addr (sprite_addr),
        .sprite_dout (sprite_dout),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    logic [15:0] wram [32768];
    logic [15:0] model_bank [2][1024];
    int          model_front = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          rd_total = 0;
    int          rd_base = 0;
    bit          rand_lat = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Work-RAM slave: optional random latency, checks address order and stability.
    task automatic responder();
        bit          seen = 1'b0;
        int          lat = 0;
        logic [14:0] hold = '0;
        forever begin
            @(negedge clk);
            if (reset_n && wram_rd && !wram_ack) begin
                if (!seen) begin
                    seen = 1'b1;
                    lat  = rand_lat ? int'($urandom_range(0, 7)) : 0;
                    hold = wram_addr;
                end
                if (lat == 0) begin
                    check_val("wram_addr_stable", 32'(wram_addr), 32'(hold));
                    check_val("wram_addr_seq", 32'(wram_addr),
                              32'(15'(BASE + 15'(rd_total - rd_base))));
                    wram_dout = wram[wram_addr];
                    wram_ack  = 1'b1;
                    rd_total++;
                end else begin
                    lat--;
                end
            end else begin
                wram_ack = 1'b0;
                seen     = 1'b0;
            end
        end
    endtask

    task automatic fill_src(input bit rnd, input logic [15:0] key);
        for (int n = 0; n < 1024; n++) begin
            logic [15:0] v;
            v = rnd ? 16'($urandom) : (16'(n) ^ key);
            if (n % 4 == 2 && v == 16'h0000) v = 16'h0001;
            wram[15'(BASE + 15'(n))] = v;
        end
    endtask

    // A completed copy lands in the back bank, then the banks flip.
    task automatic commit_model(input int cut);
        for (int i = 0; i < 1024; i++) begin
            model_bank[1 - model_front][i] = (i < cut) ? wram[15'(BASE + 15'(i))] : 16'h0000;
        end
        model_front = 1 - model_front;
    endtask

    task automatic readback(input int lo, input int hi);
        logic [15:0] q[$];
        for (int a = lo; a <= hi + 1; a++) begin
            @(negedge clk);
            if (q.size() > 0) check_val("sprite_dout", 32'(sprite_dout), 32'(q.pop_front()));
            if (a <= hi) begin
                sprite_addr = 10'(a);
                q.push_back(model_bank[model_front][a]);
            end
        end
    endtask

    task automatic pulse_vs();
        @(negedge clk);
        vs = 1'b0;
        repeat (3) @(negedge clk);
        vs = 1'b1;
    endtask

    task automatic start_dma(output logic rd_at, output logic [14:0] addr_at);
        rd_base = rd_total;
        @(negedge clk);
        vs = 1'b0;
        @(negedge clk);
        rd_at   = wram_rd;
        addr_at = wram_addr;
        repeat (2) @(negedge clk);
        vs = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy && i < 40000) begin
            @(negedge clk);
            i++;
        end
        check_val(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        logic        rd_at;
        logic [14:0] addr_at;
        int          busy_cycles;
        int          rd_high;
        int          guard;

        fork
            responder();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_wram_rd", 32'(wram_rd), 32'd0);
        check_val("rst_wram_addr", 32'(wram_addr), 32'(BASE));
        check_val("rst_sprite_dout", 32'(sprite_dout), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_overrun", 32'(overrun), 32'd0);
        check_val("rst_front", 32'(dut.front_q), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic copy, zero-wait acks
        fill_src(1'b0, 16'hA5A5);
        rd_base = rd_total;
        vs = 1'b0;
        @(negedge clk);
        check_val("trig_latency_rd", 32'(wram_rd), 32'd1);
        check_val("first_addr", 32'(wram_addr), 32'(BASE));
        busy_cycles = 0;
        for (int i = 0; i < 40000 && busy; i++) begin
            busy_cycles++;
            if (i == 2) vs = 1'b1;
            @(negedge clk);
        end
        check_val("busy_cycles", 32'(busy_cycles), 32'd2049);
        check_val("basic_front", 32'(dut.front_q), 32'd1);
        check_val("basic_reads", 32'(rd_total - rd_base), 32'(WORDS));
        commit_model(WORDS);
        @(negedge clk);
        sprite_addr = 10'h3FF;
        @(negedge clk);
        check_val("dout_3ff", 32'(sprite_dout), 32'hA65A);
        readback(0, 1023);

        // Random ack latency
        rand_lat = 1'b1;
        fill_src(1'b1, 16'h0000);
        start_dma(rd_at, addr_at);
        wait_idle("rand_done");
        check_val("rand_front", 32'(dut.front_q), 32'd0);
        check_val("rand_reads", 32'(rd_total - rd_base), 32'(WORDS));
        commit_model(WORDS);
        readback(0, 1023);

        // Overrun: second vsync fall during the copy
        fill_src(1'b1, 16'h0000);
        start_dma(rd_at, addr_at);
        repeat (495) @(negedge clk);
        check_val("overrun_pre", 32'(overrun), 32'd0);
        pulse_vs();
        @(negedge clk);
        check_val("overrun_set", 32'(overrun), 32'd1);
        wait_idle("ovr_done");
        commit_model(WORDS);
        repeat (50) @(negedge clk);
        check_val("ovr_no_restart", 32'(busy), 32'd0);
        check_val("ovr_single_flip", 32'(dut.front_q), 32'(model_front));
        check_val("ovr_reads", 32'(rd_total - rd_base), 32'(WORDS));
        check_val("overrun_sticky", 32'(overrun), 32'd1);
        readback(0, 1023);

        // dma_en low: trigger ignored
        dma_en = 1'b0;
        sprite_addr = 10'd77;
        repeat (2) @(negedge clk);
        check_val("dis_dout_pre", 32'(sprite_dout), 32'(model_bank[model_front][77]));
        start_dma(rd_at, addr_at);
        check_val("dis_rd_at", 32'(rd_at), 32'd0);
        rd_high = 0;
        for (int i = 0; i < 20; i++) begin
            if (wram_rd) rd_high++;
            @(negedge clk);
        end
        check_val("dis_no_rd", 32'(rd_high), 32'd0);
        check_val("dis_front", 32'(dut.front_q), 32'(model_front));
        check_val("dis_dout_post", 32'(sprite_dout), 32'(model_bank[model_front][77]));
        dma_en = 1'b1;

        // Reset at word 300
        rand_lat = 1'b0;
        fill_src(1'b0, 16'h1234);
        start_dma(rd_at, addr_at);
        guard = 0;
        while (rd_total - rd_base < 300 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check_val("reached_word300", 32'(rd_total - rd_base >= 300), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_val("rstmid_wram_rd", 32'(wram_rd), 32'd0);
        check_val("rstmid_front", 32'(dut.front_q), 32'd0);
        check_val("rstmid_busy", 32'(busy), 32'd0);
        model_front = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        start_dma(rd_at, addr_at);
        check_val("restart_rd", 32'(rd_at), 32'd1);
        check_val("restart_addr", 32'(addr_at), 32'(BASE));
        wait_idle("restart_done");
        check_val("restart_front", 32'(dut.front_q), 32'd1);
        commit_model(WORDS);
        readback(0, 1023);

`ifdef PGM_SPRITE_DMA_EOL_EN
        // End of list at entry 2's size word
        rand_lat = 1'b1;
        fill_src(1'b1, 16'h0000);
        wram[15'(BASE + 15'd10)] = 16'h0000;
        start_dma(rd_at, addr_at);
        wait_idle("eol_done");
        check_val("eol_reads", 32'(rd_total - rd_base), 32'd11);
        check_val("eol_front", 32'(dut.front_q), 32'd0);
        commit_model(10);
        readback(0, 1023);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pgm_sprite_dma.md
# pgm_sprite_dma

Sprite-list DMA and double buffer feeding `pgm_video`'s sprite scanner. At each vertical sync this block copies the 1024-word sprite attribute table from work RAM into a back bank, then flips banks so the video engine always scans a stable, complete list. It also serves the video engine's `sprite_addr`/`sprite_dout` read port from the front bank.

## Interface
Parameters:
- `WORDS`, default 1024: words copied per frame; must be a power of two, at most 1024.
- `WRAM_BASE`, default 15'h0000: word address of the sprite table in work RAM.

Ports:
- `clk`  in  1  system clock, shared with `pgm_video`.
- `reset_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `vs`  in  1  active-low vsync from `pgm_video`. A falling edge is the DMA trigger.
- `dma_en`  in  1  when low, triggers are ignored. A running DMA completes regardless.
- `wram_rd`  out  1  work-RAM read request. Held high until acknowledged.
- `wram_addr`  out  15  work-RAM word address. Stable while `wram_rd` is high.
- `wram_ack`  in  1  one-cycle pulse; `wram_dout` is valid in the same cycle.
- `wram_dout`  in  16  work-RAM read data.
- `sprite_addr`  in  10  video read address (word index).
- `sprite_dout`  out  16  front-bank data, registered.
- `busy`  out  1  high while a DMA is in progress.
- `overrun`  out  1  sticky. Set when a trigger arrives while `busy` is high. Cleared only by reset.

## Operation
- Storage: two banks of 1024x16. `front` selects the bank the video engine reads; the DMA writes only `~front`.
- `vs` is registered once. A trigger is `vs_q & ~vs`.
- States:
  - IDLE: on a trigger with `dma_en` high, go to READ with `cnt`=0. On a trigger with `dma_en` low, stay in IDLE.
  - READ: drive `wram_rd`=1 and `wram_addr`=`WRAM_BASE`+`cnt`. On `wram_ack`:
    - Write `wram_dout` to `back[cnt]`.
    - Advance `cnt`.
    - Drop `wram_rd` for exactly one cycle.
    - If `cnt`==`WORDS`-1, go to SWAP.
  - FILL (EOL build only): write 0 to `back[cnt]` each cycle with no work-RAM access. After `cnt`==1023, go to SWAP.
  - SWAP: toggle `front`, then go to IDLE. This state lasts 1 cycle.
- `busy` = state is not IDLE.
- Trigger while busy: the trigger is dropped, `overrun` is set to 1, and the DMA continues.
- `wram_addr` arithmetic is 15-bit and wraps modulo 2^15.
- Words `WORDS`..1023 of the back bank keep their previous contents in the non-EOL build.
- Video read port: `sprite_dout` <= `front_bank[sprite_addr]` on every clock. A bank flip takes effect on the first read issued after the SWAP edge.

## Timing
- Reset values:
  - `wram_rd`=0, `wram_addr`=`WRAM_BASE`, `sprite_dout`=0
  - `busy`=0, `overrun`=0, `front`=0, state IDLE, `cnt`=0
  - Bank contents are undefined.
- Trigger latency: `wram_rd` rises 1 cycle after the clock in which the `vs` falling edge is sampled.
- Each word takes at least 2 cycles: request, then ack, then one idle cycle. With zero-wait acks a full copy takes 2*`WORDS` cycles + 1 SWAP cycle. At 1024 words that is 2049 cycles, which fits inside 125 lines x 800 clocks of vblank.
- `wram_ack` while `wram_rd` is low is ignored.
- Reset asserted mid-DMA:
  - `wram_rd` drops immediately.
  - `front` returns to 0.
  - No partial flip occurs. The next trigger restarts from word 0.
- Read latency: `sprite_dout` is valid 1 cycle after `sprite_addr`.

## Configuration
- `PGM_SPRITE_DMA_EOL_EN` defined: end-of-list detection is enabled.
  - An entry is 4 words starting at `cnt[1:0]`==0.
  - If the word at `cnt[1:0]`==2 (size word) reads 16'h0000, the entry is terminated.
  - That word is written as 0. The 4th word is not read; it and all remaining words up to 1023 are zero-filled via FILL at one word per cycle. Then SWAP.
- Macro undefined: FILL does not exist, and all `WORDS` words are always copied.

## Structure
- `pgm_video_pkg` holds:
  - the `dma_state_t` enum (IDLE, READ, FILL, SWAP);
  - `SPR_WORDS_PER_ENTRY`=4;
  - `SPR_SIZE_WORD_IDX`=2.
- Sub-module `pgm_sprite_bank_ram`: a single 1024x16 simple dual-port RAM with one write port, one registered read port, and `clk` only. It is instantiated twice. Bank muxing and the state machine stay in `pgm_sprite_dma`.

## Test plan
- Basic copy:
  - Stimulus: work RAM word n = n^16'hA5A5, zero-wait acks, one `vs` fall.
  - Response: `busy` high for 2049 cycles, `front` goes to 1, reading `sprite_addr`=10'h3FF returns 16'hA65A.
- Random ack latency:
  - Stimulus: ack delays of 0–7 cycles.
  - Response: `wram_addr` is stable while `wram_rd` is high, and the back bank matches the source exactly.
- Overrun:
  - Stimulus: a second `vs` fall 500 cycles into a DMA.
  - Response: `overrun`=1, exactly one bank flip, and the copy is complete.
- `dma_en`=0:
  - Stimulus: `vs` falls with `dma_en` low.
  - Response: no `wram_rd`, `front` unchanged, `sprite_dout` unchanged.
- Reset mid-DMA:
  - Stimulus: `reset_n` asserted at word 300.
  - Response: `wram_rd`=0 and `front`=0 on the same edge; the next trigger starts at `WRAM_BASE`.
- EOL build:
  - Stimulus: word 10 (entry 2, size word) = 0.
  - Response: words 10–1023 of the new front bank read 0, and exactly 11 work-RAM reads are issued.
